// File: rtl/s2p_deser.sv
// s2p_deser: serial-to-parallel deserializer, LSB/MSB-first, back-to-back frames, wrapping frame count.
// Define S2P_PARITY_EN to take a trailing even-parity bit per frame and report parity_err.
module s2p_deser #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             din,
    input  logic             din_valid,
    input  logic             msb_first,
    output logic [WIDTH-1:0] out_p,
    output logic             ready,
    output logic             busy,
    output logic [CNT_W-1:0] frame_cnt
`ifdef S2P_PARITY_EN
    ,
    output logic             parity_err
`endif
);
    localparam int BW = $clog2(WIDTH + 1);
`ifdef S2P_PARITY_EN
    typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;
`else
    typedef enum logic [1:0] {IDLE, SHIFT} state_t;
`endif
    state_t           state;
    logic [WIDTH-1:0] sr;
    logic [BW-1:0]    cnt;
    logic             ord;
    logic             first;
    logic             last;
    logic             o;
    logic [WIDTH-1:0] nxt;
    // bit 0 of every frame (from IDLE or back-to-back) uses the live msb_first
    assign first = cnt == '0;
    assign last  = cnt == BW'(WIDTH - 1);
    assign o     = first ? msb_first : ord;
    assign nxt   = o ? {sr[WIDTH-2:0], din} : {din, sr[WIDTH-1:1]};
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            sr        <= '0;
            cnt       <= '0;
            ord       <= 1'b0;
            out_p     <= '0;
            ready     <= 1'b0;
            busy      <= 1'b0;
            frame_cnt <= '0;
`ifdef S2P_PARITY_EN
            parity_err <= 1'b0;
`endif
        end else begin
            ready <= 1'b0;
            if (!start) begin
                state <= IDLE;
                busy  <= 1'b0;
                cnt   <= '0;
                sr    <= '0;
            end else if (din_valid) begin
                busy <= 1'b1;
`ifdef S2P_PARITY_EN
                if (state == PARITY) begin
                    out_p      <= sr;
                    parity_err <= ^{sr, din};
                    ready      <= 1'b1;
                    frame_cnt  <= frame_cnt + 1'b1;
                    state      <= SHIFT;
                end else begin
`else
                begin
`endif
                    sr <= nxt;
                    if (first) ord <= msb_first;
                    if (last) begin
                        cnt <= '0;
`ifdef S2P_PARITY_EN
                        state <= PARITY;
`else
                        state     <= SHIFT;
                        out_p     <= nxt;
                        ready     <= 1'b1;
                        frame_cnt <= frame_cnt + 1'b1;
`endif
                    end else begin
                        state <= SHIFT;
                        cnt   <= cnt + 1'b1;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_s2p_deser.sv
// tb_s2p_deser: directed vectors for s2p_deser (WIDTH=8, CNT_W=8).
module tb_s2p_deser;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       din = 1'b0;
    logic       din_valid = 1'b0;
    logic       msb_first = 1'b0;
    logic [7:0] out_p;
    logic       ready;
    logic       busy;
    logic [7:0] frame_cnt;
`ifdef S2P_PARITY_EN
    logic       parity_err;
`endif
    int pass_cnt = 0;
    int total = 0;

    always #5 clk = ~clk;

    s2p_deser #(.WIDTH(8), .CNT_W(8)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .din(din),
        .din_valid(din_valid),
        .msb_first(msb_first),
        .out_p(out_p),
        .ready(ready),
        .busy(busy),
        .frame_cnt(frame_cnt)
`ifdef S2P_PARITY_EN
        ,
        .parity_err(parity_err)
`endif
    );

    typedef struct {
        logic       s, v, d, m, rdy, bsy;
        logic [7:0] out, cnt;
    } vec_t;

    vec_t tbl[9];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    task automatic cyc(input logic s, input logic v, input logic d, input logic m);
        start = s; din_valid = v; din = d; msb_first = m;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] w;
        logic [7:0] words[3];
        int k;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out", out_p, 8'h00);
        chk("rst_ready", ready, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_cnt", frame_cnt, 8'h00);
        rst_n = 1'b1;
        cyc(0, 0, 0, 0);
`ifdef S2P_PARITY_EN
        w = 8'h0D;
        for (int p = 1; p >= 0; p--) begin
            for (int b = 0; b < 8; b++) begin
                cyc(1, 1, w[b], 0);
                chk("par_data_ready", ready, 1'b0);
            end
            cyc(1, 1, p[0], 0);
            chk("par_ready", ready, 1'b1);
            chk("par_out", out_p, 8'h0D);
            chk("par_err", parity_err, !p[0]);
        end
        cyc(0, 0, 0, 0);
        chk("par_idle_ready", ready, 1'b0);
`else
        w = 8'h0D;
        for (int i = 0; i < 8; i++)
            tbl[i] = '{1'b1, 1'b1, w[i], 1'b0, i == 7, 1'b1, (i == 7) ? 8'h0D : 8'h00, (i == 7) ? 8'h01 : 8'h00};
        tbl[8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h0D, 8'h01};
        for (int i = 0; i < 9; i++) begin
            cyc(tbl[i].s, tbl[i].v, tbl[i].d, tbl[i].m);
            chk($sformatf("tbl%0d_ready", i), ready, tbl[i].rdy);
            chk($sformatf("tbl%0d_busy", i), busy, tbl[i].bsy);
            chk($sformatf("tbl%0d_out", i), out_p, tbl[i].out);
            chk($sformatf("tbl%0d_cnt", i), frame_cnt, tbl[i].cnt);
        end
        // MSB-first with gaps; msb_first drops after bit 0 and must not affect this frame
        k = 0;
        for (int i = 0; i < 16; i++) begin
            cyc(1, i % 2 == 0, (i % 2 == 0) ? w[k] : 1'b0, i == 0);
            if (i % 2 == 0) k++;
            chk($sformatf("gap%0d_ready", i), ready, i == 14);
            chk($sformatf("gap%0d_busy", i), busy, 1'b1);
        end
        chk("gap_out", out_p, 8'hB0);
        chk("gap_cnt", frame_cnt, 8'h02);
        cyc(0, 0, 0, 0);
        chk("gap_idle_busy", busy, 1'b0);
        words = '{8'hFF, 8'h00, 8'hA5};
        for (int f = 0; f < 3; f++)
            for (int b = 0; b < 8; b++) begin
                cyc(1, 1, words[f][b], 0);
                chk($sformatf("b2b%0d_%0d_ready", f, b), ready, b == 7);
                if (b == 7) chk($sformatf("b2b%0d_out", f), out_p, words[f]);
            end
        chk("b2b_cnt", frame_cnt, 8'h05);
        cyc(0, 0, 0, 0);
        for (int b = 0; b < 5; b++) begin
            cyc(1, 1, 1, 0);
            chk("abort_part_ready", ready, 1'b0);
        end
        cyc(0, 1, 1, 0);
        chk("abort_ready", ready, 1'b0);
        chk("abort_busy", busy, 1'b0);
        chk("abort_out", out_p, 8'hA5);
        chk("abort_cnt", frame_cnt, 8'h05);
        w = 8'h3C;
        for (int b = 0; b < 8; b++) begin
            cyc(1, 1, w[b], 0);
            chk($sformatf("post_abort%0d_ready", b), ready, b == 7);
        end
        chk("post_abort_out", out_p, 8'h3C);
        chk("post_abort_cnt", frame_cnt, 8'h06);
        for (int b = 0; b < 7; b++) cyc(1, 1, b[0], 0);
        cyc(0, 1, 1, 0);
        chk("lastbit_abort_ready", ready, 1'b0);
        chk("lastbit_abort_out", out_p, 8'h3C);
        chk("lastbit_abort_busy", busy, 1'b0);
        chk("lastbit_abort_cnt", frame_cnt, 8'h06);
        cyc(0, 0, 0, 0);
        chk("lastbit_abort_ready2", ready, 1'b0);
        for (int f = 0; f < 249; f++)
            for (int b = 0; b < 8; b++) cyc(1, 1, 0, 0);
        chk("wrap_pre_cnt", frame_cnt, 8'hFF);
        for (int b = 0; b < 8; b++) cyc(1, 1, 0, 0);
        chk("wrap_cnt", frame_cnt, 8'h00);
        chk("wrap_ready", ready, 1'b1);
        cyc(0, 0, 0, 0);
        w = 8'h5A;
        for (int b = 0; b < 8; b++) cyc(1, 1, w[b], 0);
        chk("pre_rst_out", out_p, 8'h5A);
        chk("pre_rst_cnt", frame_cnt, 8'h01);
        for (int b = 0; b < 3; b++) cyc(1, 1, 1, 0);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_out", out_p, 8'h00);
        chk("mid_rst_ready", ready, 1'b0);
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_cnt", frame_cnt, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
`endif
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule
